// File: rtl/bram_be_pipe.sv
// Simple-dual-port block RAM with byte enables, a 1..3 cycle read pipeline and selectable read-during-write.
// Define BRAM_BE_PIPE_PARITY_EN to store one even-parity bit per byte and flag parity errors on reads.
module bram_be_pipe #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en_i,
    input  logic [DATA_W/8-1:0] wr_be_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic                rd_en_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                rd_valid_o,
    output logic                rd_perr_o
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
`ifdef BRAM_BE_PIPE_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif

    typedef logic [LANE_W-1:0]        lane_t;
    typedef logic [NB-1:0][LANE_W-1:0] word_t;

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
        $fatal(1, "bram_be_pipe: RD_LAT must be 1, 2 or 3");
    end
    if (DATA_W % 8 != 0) begin : g_bad_width
        $fatal(1, "bram_be_pipe: DATA_W must be a multiple of 8");
    end

    // A stored lane is the data byte, with its even-parity bit on top when parity is enabled.
    function automatic lane_t make_lane(input logic [7:0] b);
`ifdef BRAM_BE_PIPE_PARITY_EN
        return {^b, b};
`else
        return b;
`endif
    endfunction

    word_t mem [DEPTH] = '{default: '0};

    // NOTE: the array has no reset so it maps onto block RAM; contents only start at zero.
    always_ff @(posedge clk) begin
        if (rst && wr_en_i) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be_i[k]) begin
                    mem[wr_addr_i][k] <= make_lane(wr_data_i[8*k +: 8]);
                end
            end
        end
    end

    logic  same_addr;
    word_t s0_word;
    logic  s0_valid;

    assign same_addr = wr_en_i && (wr_addr_i == rd_addr_i);

    // NOTE: registers take <= so every stage samples the pre-edge value of the one before it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_valid <= 1'b0;
            s0_word  <= '0;
        end else begin
            s0_valid <= rd_en_i;
            if (rd_en_i) begin
                for (int k = 0; k < NB; k++) begin
                    if (RDW_MODE == 1 && same_addr && wr_be_i[k]) begin
                        s0_word[k] <= make_lane(wr_data_i[8*k +: 8]);
                    end else begin
                        s0_word[k] <= mem[rd_addr_i][k];
                    end
                end
            end
        end
    end

    logic [DATA_W-1:0] s0_data;
    logic              s0_perr;

    // NOTE: defaults first so no path through the block leaves a value unassigned (no latch).
    always_comb begin
        s0_data = '0;
        s0_perr = 1'b0;
        for (int k = 0; k < NB; k++) begin
            s0_data[8*k +: 8] = s0_word[k][7:0];
`ifdef BRAM_BE_PIPE_PARITY_EN
            s0_perr = s0_perr | (^s0_word[k]);
`endif
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        assign rd_data_o  = s0_data;
        assign rd_valid_o = s0_valid;
        assign rd_perr_o  = s0_valid & s0_perr;
    end else begin : g_pipe
        localparam int NS = RD_LAT - 1;

        logic [NS-1:0][DATA_W-1:0] q_data;
        logic [NS-1:0]             q_valid;
        logic [NS-1:0]             q_perr;

        // Data and parity status only advance with a valid read so the output holds between strobes.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                q_data  <= '0;
                q_valid <= '0;
                q_perr  <= '0;
            end else begin
                q_valid[0] <= s0_valid;
                if (s0_valid) begin
                    q_data[0] <= s0_data;
                    q_perr[0] <= s0_perr;
                end
                for (int i = 1; i < NS; i++) begin
                    q_valid[i] <= q_valid[i-1];
                    if (q_valid[i-1]) begin
                        q_data[i] <= q_data[i-1];
                        q_perr[i] <= q_perr[i-1];
                    end
                end
            end
        end

        assign rd_data_o  = q_data[NS-1];
        assign rd_valid_o = q_valid[NS-1];
        assign rd_perr_o  = q_valid[NS-1] & q_perr[NS-1];
    end

endmodule

// File: tb/tb_bram_be_pipe.sv
// Bench for bram_be_pipe: three instances (latency 1/2/3, mixed read-during-write modes) share one stimulus
// and are compared every cycle against a word-level reference memory and per-instance expected-read queues.
module tb_bram_be_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_be;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [7:0]  rd_addr;

    logic [31:0] rdata  [3];
    logic        rvalid [3];
    logic        rperr  [3];

    int lat  [3] = '{1, 2, 3};
    int mode [3] = '{0, 1, 0};

    always #5 clk = ~clk;

    bram_be_pipe #(.DATA_W(32), .ADDR_W(8), .RD_LAT(1), .RDW_MODE(0)) u0 (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_be_i(wr_be), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rdata[0]), .rd_valid_o(rvalid[0]), .rd_perr_o(rperr[0]));

    bram_be_pipe #(.DATA_W(32), .ADDR_W(8), .RD_LAT(2), .RDW_MODE(1)) u1 (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_be_i(wr_be), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rdata[1]), .rd_valid_o(rvalid[1]), .rd_perr_o(rperr[1]));

    bram_be_pipe #(.DATA_W(32), .ADDR_W(8), .RD_LAT(3), .RDW_MODE(0)) u2 (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_be_i(wr_be), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rdata[2]), .rd_valid_o(rvalid[2]), .rd_perr_o(rperr[2]));

    typedef struct {
        int unsigned due;
        logic [31:0] data;
        logic        perr;
    } exp_t;

    typedef struct {
        logic        wr_en;
        logic [3:0]  be;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic        rd_en;
        logic [7:0]  raddr;
        logic        exp_v;
        logic [31:0] exp_d;
    } vec_t;

    logic [31:0] shadow  [256];
    logic        corrupt [256];
    exp_t        exp_q   [3][$];
    logic [31:0] last    [3];
    int unsigned cyc;
    int          n_checks;
    int          n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
        return m;
    endfunction

    task automatic drive(input logic we, input logic [3:0] be, input logic [7:0] wa,
                         input logic [31:0] wd, input logic re, input logic [7:0] ra);
        wr_en = we; wr_be = be; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            if (exp_q[i].size() != 0 && exp_q[i][0].due == cyc) begin
                e = exp_q[i].pop_front();
                check($sformatf("valid_u%0d", i), 32'(rvalid[i]), 32'd1);
                check($sformatf("data_u%0d", i), rdata[i], e.data);
                check($sformatf("perr_u%0d", i), 32'(rperr[i]), 32'(e.perr));
                last[i] = e.data;
            end else begin
                check($sformatf("idle_valid_u%0d", i), 32'(rvalid[i]), 32'd0);
                check($sformatf("hold_data_u%0d", i), rdata[i], last[i]);
                check($sformatf("idle_perr_u%0d", i), 32'(rperr[i]), 32'd0);
            end
        end
    endtask

    // Model the edge with the inputs currently driven, then clock and compare every instance.
    task automatic tick();
        logic [31:0] m;
        logic [31:0] old;
        logic [31:0] d;
        logic        p;
        m = lane_mask(wr_be);
        if (rst) begin
            old = shadow[rd_addr];
            if (rd_en) begin
                for (int i = 0; i < 3; i++) begin
                    d = old;
                    if (mode[i] == 1 && wr_en && wr_addr == rd_addr) d = (old & ~m) | (wr_data & m);
`ifdef BRAM_BE_PIPE_PARITY_EN
                    p = corrupt[rd_addr];
`else
                    p = 1'b0;
`endif
                    exp_q[i].push_back('{due: cyc + lat[i], data: d, perr: p});
                end
            end
            if (wr_en) shadow[wr_addr] = (shadow[wr_addr] & ~m) | (wr_data & m);
        end
        @(posedge clk);
        cyc++;
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted mid-cycle: everything in flight is gone and outputs drop at once.
    task automatic reset_now();
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q[i].delete();
            last[i] = 32'h0;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_valid_u%0d", i), 32'(rvalid[i]), 32'd0);
            check($sformatf("rst_data_u%0d", i), rdata[i], 32'd0);
            check($sformatf("rst_perr_u%0d", i), 32'(rperr[i]), 32'd0);
        end
    endtask

    vec_t        tbl [12];
    logic [31:0] got [3][$];
    int unsigned first_cyc [3];
    int unsigned last_cyc  [3];
    int unsigned c0;

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        for (int a = 0; a < 256; a++) begin
            shadow[a]  = 32'h0;
            corrupt[a] = 1'b0;
        end
        for (int i = 0; i < 3; i++) last[i] = 32'h0;

        tbl[0]  = '{1'b0, 4'h0, 8'h00, 32'h0,        1'b1, 8'h05, 1'b1, 32'h00000000};
        tbl[1]  = '{1'b1, 4'hF, 8'h10, 32'hAABBCCDD, 1'b0, 8'h00, 1'b0, 32'h00000000};
        tbl[2]  = '{1'b1, 4'h5, 8'h10, 32'h11223344, 1'b0, 8'h00, 1'b0, 32'h00000000};
        tbl[3]  = '{1'b0, 4'h0, 8'h00, 32'h0,        1'b1, 8'h10, 1'b1, 32'hAA22CC44};
        tbl[4]  = '{1'b1, 4'hF, 8'h20, 32'h12345678, 1'b0, 8'h00, 1'b0, 32'hAA22CC44};
        tbl[5]  = '{1'b1, 4'h3, 8'h20, 32'hFFFFFFFF, 1'b1, 8'h20, 1'b1, 32'h12345678};
        tbl[6]  = '{1'b0, 4'h0, 8'h00, 32'h0,        1'b1, 8'h20, 1'b1, 32'h1234FFFF};
        tbl[7]  = '{1'b1, 4'h0, 8'h21, 32'hDEADBEEF, 1'b1, 8'h21, 1'b1, 32'h00000000};
        tbl[8]  = '{1'b0, 4'h0, 8'h00, 32'h0,        1'b1, 8'h21, 1'b1, 32'h00000000};
        tbl[9]  = '{1'b1, 4'hF, 8'h22, 32'hCAFEF00D, 1'b1, 8'h23, 1'b1, 32'h00000000};
        tbl[10] = '{1'b0, 4'h0, 8'h00, 32'h0,        1'b1, 8'h22, 1'b1, 32'hCAFEF00D};
        tbl[11] = '{1'b0, 4'h0, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 32'hCAFEF00D};

        // Reset held: traffic is ignored and outputs stay zero.
        rst = 1'b0;
        drive(1'b1, 4'hF, 8'h05, 32'hFFFFFFFF, 1'b1, 8'h05);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t0_valid_u%0d", i), 32'(rvalid[i]), 32'd0);
            check($sformatf("t0_data_u%0d", i), rdata[i], 32'd0);
            check($sformatf("t0_perr_u%0d", i), 32'(rperr[i]), 32'd0);
        end
        for (int t = 0; t < 3; t++) tick();
        rst = 1'b1;

        // Directed vectors; instance u0 (latency 1, old-data) is also checked against the table.
        for (int v = 0; v < 12; v++) begin
            drive(tbl[v].wr_en, tbl[v].be, tbl[v].waddr, tbl[v].wdata, tbl[v].rd_en, tbl[v].raddr);
            tick();
            check($sformatf("vec%0d_valid", v), 32'(rvalid[0]), 32'(tbl[v].exp_v));
            check($sformatf("vec%0d_data", v), rdata[0], tbl[v].exp_d);
        end
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
        for (int t = 0; t < 3; t++) tick();

        // Two reads in flight, reset between edges, writes ignored during reset, nothing after release.
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h22);
        tick();
        tick();
        reset_now();
        drive(1'b1, 4'hF, 8'h23, 32'h00000055, 1'b1, 8'h22);
        tick();
        tick();
        rst = 1'b1;
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
        for (int t = 0; t < 4; t++) tick();
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h23);
        tick();
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
        for (int t = 0; t < 3; t++) tick();

        // Throughput: fill 0..7, then eight back-to-back reads.
        for (int a = 0; a < 8; a++) begin
            drive(1'b1, 4'hF, 8'(a), 32'(a) * 32'h01010101, 1'b0, 8'h00);
            tick();
        end
        c0 = cyc;
        for (int t = 0; t < 12; t++) begin
            if (t < 8) drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'(t));
            else       drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
            tick();
            for (int i = 0; i < 3; i++) begin
                if (rvalid[i] === 1'b1) begin
                    if (got[i].size() == 0) first_cyc[i] = cyc;
                    got[i].push_back(rdata[i]);
                    last_cyc[i] = cyc;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("burst_count_u%0d", i), 32'(got[i].size()), 32'd8);
            if (got[i].size() == 8) begin
                check($sformatf("burst_first_u%0d", i), first_cyc[i] - c0, 32'(lat[i]));
                check($sformatf("burst_span_u%0d", i), last_cyc[i] - first_cyc[i], 32'd7);
                for (int k = 0; k < 8; k++)
                    check($sformatf("burst_data_u%0d_%0d", i, k), got[i][k], 32'(k) * 32'h01010101);
            end
        end

        // Random traffic on a small address window so read-during-write collisions are common.
        for (int t = 0; t < 400; t++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom), 8'h40 + 8'($urandom_range(0, 7)),
                  $urandom, 1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 7)));
            tick();
        end
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
        for (int t = 0; t < 4; t++) tick();

`ifdef BRAM_BE_PIPE_PARITY_EN
        // Corrupt one stored bit behind the RAM's back; the read of that word must flag a parity error.
        drive(1'b1, 4'hF, 8'h30, 32'h0F0F0F0F, 1'b0, 8'h00);
        tick();
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
        tick();
        u0.mem[8'h30][0][0] = ~u0.mem[8'h30][0][0];
        u1.mem[8'h30][0][0] = ~u1.mem[8'h30][0][0];
        u2.mem[8'h30][0][0] = ~u2.mem[8'h30][0][0];
        shadow[8'h30]  = shadow[8'h30] ^ 32'h1;
        corrupt[8'h30] = 1'b1;
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h30);
        tick();
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h31);
        tick();
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
        for (int t = 0; t < 4; t++) tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bram_be_pipe.md
# bram_be_pipe

Parametrised simple-dual-port block RAM with per-byte write enables, a configurable read pipeline of 1–3 cycles, a read-valid strobe and selectable read-during-write behaviour. It is the general-purpose storage primitive for packet buffers, descriptor tables and counters in the Ethernet datapath. It is the successor to the fixed single-cycle, word-write RAM.

## Interface
Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 12, address width; depth = 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles; legal values 1, 2, 3.
- RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new data forwarded.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- wr_en_i  in  1  write request.
- wr_be_i  in  DATA_W/8  byte enables; bit k covers wr_data_i[8k+7:8k].
- wr_addr_i  in  ADDR_W  write address.
- wr_data_i  in  DATA_W  write data.
- rd_en_i  in  1  read request.
- rd_addr_i  in  ADDR_W  read address.
- rd_data_o  out  DATA_W  read data; meaningful when rd_valid_o = 1.
- rd_valid_o  out  1  one-cycle strobe marking rd_data_o valid.
- rd_perr_o  out  1  parity error on the current read, qualified by rd_valid_o.

## Operation
- Write: a byte lane is written when wr_en_i = 1 and its wr_be_i bit = 1. Lanes with wr_be_i = 0 keep their contents. wr_en_i = 1 with wr_be_i = 0 is a no-op.
- Read: rd_en_i = 1 samples rd_addr_i. The array is read once, then the result passes through RD_LAT−1 further register stages. A valid bit travels alongside the data.
- No backpressure: a read can be issued every cycle and results are never stalled or dropped.
- rd_data_o holds its last valid value while rd_valid_o = 0.
- Read-during-write, same address, same cycle:
  - RDW_MODE = 0: returns the pre-write word.
  - RDW_MODE = 1: enabled lanes return wr_data_i and disabled lanes return the stored bytes, i.e. a per-byte merge.
- Different addresses are independent in the same cycle.
- A read issued in the cycle after a write to the same address always returns the new data.
- Memory contents are zero at time 0 and are not cleared by rst.
- Reset:
  - rst = 0 asynchronously clears rd_valid_o, rd_data_o and rd_perr_o to 0, including every pipeline stage.
  - Reads in flight are discarded.
  - Writes are ignored while rst = 0.

## Timing
- A read accepted at edge N produces rd_valid_o = 1 and its data during the cycle after edge N+RD_LAT−1, i.e. RD_LAT cycles after issue.
- Back-to-back reads at consecutive edges produce back-to-back valid strobes in the same order.
- A write at edge N is visible to a read issued at edge N+1.
- Deasserting rst re-enables operation at the first rising edge where rst = 1.
- RD_LAT outside 1..3 or DATA_W not a multiple of 8 is an elaboration error and raises $fatal.

## Configuration
- BRAM_BE_PIPE_PARITY_EN defined:
  - Each byte is stored with one even-parity bit, so the array width becomes DATA_W + DATA_W/8.
  - Parity is computed on write for each enabled lane.
  - On read, parity is checked per lane after the array stage. rd_perr_o = 1 alongside rd_valid_o if any lane mismatches, including on forwarded lanes.
  - A forwarded (RDW_MODE = 1) lane uses freshly computed parity.
- Not defined:
  - No parity bits are stored.
  - rd_perr_o is tied to 0.

## Test plan
- Reset: hold rst = 0 while issuing reads and writes. Expect rd_valid_o = 0, rd_data_o = 0 and rd_perr_o = 0 throughout. Release rst, read address 0x005, and expect 0x00000000 after RD_LAT cycles.
- Byte enables: write 0xAABBCCDD to 0x010 with be = 4'b1111, then 0x11223344 with be = 4'b0101. Read 0x010 and expect 0xAA22CC44.
- Latency and throughput: for each RD_LAT in 1, 2, 3, write addresses 0–7 with value = address × 0x01010101, then issue 8 consecutive reads. Expect 8 contiguous valid strobes starting exactly RD_LAT cycles after the first read, in order.
- Read-during-write: 0x020 holds 0x12345678. In one cycle, write 0xFFFFFFFF with be = 4'b0011 and read 0x020. Expect 0x12345678 for RDW_MODE = 0 and 0x1234FFFF for RDW_MODE = 1.
- Reset mid-flight: RD_LAT = 3, issue reads at edges N and N+1, assert rst between edges N+1 and N+2. Expect rd_valid_o to fall immediately and no valid strobe to appear after release.
- Parity (macro defined): force-flip stored bit 0 of 0x030 via a hierarchical deposit, then read 0x030. Expect rd_perr_o = 1 with rd_valid_o. A read of an untouched address returns rd_perr_o = 0.
